alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, meaning which requester (0 or 1) holds priority after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports r0_valid/r1_valid, input, 1, requester i presents an operation.
REQ-005 The block SHALL have ports r0_ready/r1_ready, output, 1, requester i operation accepted this cycle.
REQ-006 The block SHALL have ports r0_a/r1_a and r0_b/r1_b, input, 32, requester operands A and B.
REQ-007 The block SHALL have ports r0_sel/r1_sel, input, 5, requester ALU selection code, passed through unmodified.
REQ-008 The block SHALL have ports alu_a, alu_b, output, 32, and alu_sel, output, 5, driving the shared ALU.
REQ-009 The block SHALL have ports alu_out, input, 32, and alu_zero, input, 1, the shared ALU result and zero flag.
REQ-010 The block SHALL have ports p0_valid/p1_valid, output, 1, response i holds a result.
REQ-011 The block SHALL have ports p0_ready/p1_ready, input, 1, consumer i takes the response this cycle.
REQ-012 The block SHALL have ports p0_data/p1_data, output, 32, and p0_zero/p1_zero, output, 1, the registered result and zero flag.

Function
REQ-013 Eligibility SHALL be elig_i = ri_valid && (!pi_valid || pi_ready); a requester whose response slot is full and not draining SHALL NOT be granted.
REQ-014 With one eligible requester, it SHALL be granted; with both eligible, the requester named by the priority pointer ptr SHALL be granted; at most one grant per cycle.
REQ-015 ri_ready SHALL equal grant_i, combinationally, in the same cycle as ri_valid; ready may depend on valid, valid never depends on ready.
REQ-016 In a grant cycle alu_a/alu_b/alu_sel SHALL carry the granted requester's a/b/sel; with no grant they SHALL be 0/0/5'b00000.
REQ-017 On the edge ending a grant to i: pi_data <= alu_out, pi_zero <= alu_zero, pi_valid <= 1; latency from acceptance to pi_valid is exactly 1 cycle.
REQ-018 pi_valid SHALL clear on the edge where pi_valid && pi_ready and no new grant to i; drain and new grant to i in the same cycle SHALL keep pi_valid=1 with the new data (no bubble).
REQ-019 pi_data and pi_zero SHALL hold stable while pi_valid && !pi_ready.
REQ-020 After a grant to i, ptr SHALL become the other requester; with no grant ptr SHALL not change.
REQ-021 A continuously eligible requester SHALL be granted within 2 cycles (no starvation).
REQ-022 Sustained throughput SHALL be one operation per cycle total, one per cycle per requester when its responses are consumed each cycle.
REQ-023 The block SHALL not decode alu_sel; unlisted codes pass through and the ALU result is returned as given.
REQ-024 Requester operands and sel held stable while ri_valid && !ri_ready is a requester obligation; the bench SHALL assert it.

Reset
REQ-025 While rst_n=0, asynchronously: p0_valid=p1_valid=0, p0_data=p1_data=0, p0_zero=p1_zero=0, ptr=RR_INIT.
REQ-026 While rst_n=0, r0_ready=r1_ready=0 and alu_a/alu_b/alu_sel=0 regardless of inputs.
REQ-027 Reset asserted mid-operation SHALL discard any pending or in-flight result; the first grant is possible on the first rising edge after rst_n rises.

Verification
REQ-028 Reset mid-op: p0_valid=1, p0_ready=0, pull rst_n low between edges -> p0_valid=0, p0_data=0 immediately, ptr=RR_INIT.
REQ-029 Single op: r0 a=5 b=3 sel=00000, r1 idle -> r0_ready=1 same cycle, alu_a=5, alu_b=3; next cycle p0_valid=1, p0_data=8, p0_zero=0.
REQ-030 Contention, ptr=0: r0 sub 7-7 (sel 00010), r1 and 0xF0F0&0x0FF0 (sel 11100) -> cycle1 r0 granted, p0_data=0, p0_zero=1; cycle2 r1 granted, p1_data=0x000000F0.
REQ-031 Backpressure: p0_valid=1, p0_ready=0, both requesting -> r0_ready=0, r1 granted; then p0_ready=1 -> r0 granted that cycle, p0_valid stays 1 with new data.
REQ-032 Fairness: both valid 8 cycles, p0_ready=p1_ready=1 -> grants alternate 0,1,0,1,... and each pi_valid=1 every other cycle.
REQ-033 Idle: no valids for 4 cycles -> alu_a=alu_b=0, alu_sel=00000, ptr unchanged, p*_valid drain to 0 on ready.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered per-requester response slots
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [4:0]  r0_sel,
  input  logic [4:0]  r1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        p0_valid,
  output logic        p1_valid,
  input  logic        p0_ready,
  input  logic        p1_ready,
  output logic [31:0] p0_data,
  output logic [31:0] p1_data,
  output logic        p0_zero,
  output logic        p1_zero
);
  logic ptr, e0, e1, g0, g1;
  always_comb begin
    e0 = r0_valid && (!p0_valid || p0_ready);
    e1 = r1_valid && (!p1_valid || p1_ready);
    g0 = rst_n && e0 && (!e1 || !ptr);
    g1 = rst_n && e1 && (!e0 || ptr);
    r0_ready = g0;
    r1_ready = g1;
    alu_a = g0 ? r0_a : g1 ? r1_a : '0;
    alu_b = g0 ? r0_b : g1 ? r1_b : '0;
    alu_sel = g0 ? r0_sel : g1 ? r1_sel : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p0_data <= '0;
      p1_data <= '0;
      p0_zero <= 1'b0;
      p1_zero <= 1'b0;
      ptr <= RR_INIT;
    end else begin
      if (g0) begin
        p0_valid <= 1'b1;
        p0_data <= alu_out;
        p0_zero <= alu_zero;
      end else if (p0_ready) p0_valid <= 1'b0;
      if (g1) begin
        p1_valid <= 1'b1;
        p1_data <= alu_out;
        p1_zero <= alu_zero;
      end else if (p1_ready) p1_valid <= 1'b0;
      if (g0 || g1) ptr <= g0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, backpressure, fairness and reset against a small ALU model
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic [4:0] r0_sel = 0, r1_sel = 0, alu_sel;
  logic [31:0] alu_a, alu_b, alu_out, p0_data, p1_data;
  logic alu_zero, p0_valid, p1_valid, p0_zero, p1_zero;
  logic p0_ready = 0, p1_ready = 0;
  int checks = 0, errors = 0;
  logic h0 = 0, h1 = 0;
  logic [68:0] s0, s1;
  always #5 clk = ~clk;
  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b), .r0_sel(r0_sel), .r1_sel(r1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_data(p0_data), .p1_data(p1_data), .p0_zero(p0_zero), .p1_zero(p1_zero)
  );
  always_comb begin
    alu_out = alu_sel == 5'b00010 ? alu_a - alu_b : alu_sel == 5'b11100 ? alu_a & alu_b : alu_a + alu_b;
    alu_zero = alu_out == 32'd0;
  end
  always @(posedge clk) begin
    if (h0 && {r0_a, r0_b, r0_sel} != s0) $error("r0 operands changed while stalled");
    if (h1 && {r1_a, r1_b, r1_sel} != s1) $error("r1 operands changed while stalled");
    h0 <= rst_n && r0_valid && !r0_ready;
    h1 <= rst_n && r1_valid && !r1_ready;
    s0 <= {r0_a, r0_b, r0_sel};
    s1 <= {r1_a, r1_b, r1_sel};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    r0_valid = 1; r0_a = 9; r0_b = 9;
    #12;
    check("rst_r0_ready", r0_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_p0_valid", p0_valid, 0);
    check("rst_p0_data", p0_data, 0);
    check("rst_ptr", dut.ptr, 0);
    r0_valid = 0;
    @(negedge clk) rst_n = 1;
    tick();
    r0_valid = 1; r0_a = 5; r0_b = 3; r0_sel = 5'b00000;
    #1;
    check("single_r0_ready", r0_ready, 1);
    check("single_r1_ready", r1_ready, 0);
    check("single_alu_a", alu_a, 5);
    check("single_alu_b", alu_b, 3);
    tick();
    r0_valid = 0;
    check("single_p0_valid", p0_valid, 1);
    check("single_p0_data", p0_data, 8);
    check("single_p0_zero", p0_zero, 0);
    check("single_ptr", dut.ptr, 1);
    #3 rst_n = 0;
    #1;
    check("midrst_p0_valid", p0_valid, 0);
    check("midrst_p0_data", p0_data, 0);
    check("midrst_ptr", dut.ptr, 0);
    @(negedge clk) rst_n = 1;
    tick();
    p0_ready = 1; p1_ready = 1;
    r0_valid = 1; r0_a = 7; r0_b = 7; r0_sel = 5'b00010;
    r1_valid = 1; r1_a = 32'hF0F0; r1_b = 32'h0FF0; r1_sel = 5'b11100;
    #1;
    check("cont1_r0_ready", r0_ready, 1);
    check("cont1_r1_ready", r1_ready, 0);
    check("cont1_alu_sel", alu_sel, 5'b00010);
    tick();
    r0_valid = 0;
    check("cont1_p0_data", p0_data, 0);
    check("cont1_p0_zero", p0_zero, 1);
    check("cont2_r1_ready", r1_ready, 1);
    check("cont2_alu_sel", alu_sel, 5'b11100);
    tick();
    r1_valid = 0;
    check("cont2_p1_valid", p1_valid, 1);
    check("cont2_p1_data", p1_data, 32'h000000F0);
    check("cont2_p1_zero", p1_zero, 0);
    check("cont2_p0_drained", p0_valid, 0);
    p0_ready = 0;
    r0_valid = 1; r0_a = 1; r0_b = 1; r0_sel = 0;
    tick();
    check("bp_fill_p0_data", p0_data, 2);
    r0_a = 10; r0_b = 20;
    r1_valid = 1; r1_a = 3; r1_b = 4; r1_sel = 0;
    #1;
    check("bp_r0_ready", r0_ready, 0);
    check("bp_r1_ready", r1_ready, 1);
    tick();
    r1_valid = 0;
    check("bp_p1_data", p1_data, 7);
    check("bp_p0_held_valid", p0_valid, 1);
    check("bp_p0_held_data", p0_data, 2);
    p0_ready = 1;
    #1;
    check("bp_drain_r0_ready", r0_ready, 1);
    tick();
    r0_valid = 0;
    check("bp_nobubble_valid", p0_valid, 1);
    check("bp_nobubble_data", p0_data, 30);
    tick();
    check("bp_final_drain", p0_valid, 0);
    check("bp_ptr", dut.ptr, 1);
    #2 rst_n = 0;
    r0_valid = 1; r0_a = 100; r0_b = 1; r0_sel = 0;
    r1_valid = 1; r1_a = 200; r1_b = 2; r1_sel = 0;
    #1;
    check("rst_ready_gated", r0_ready | r1_ready, 0);
    check("rst_alu_b_gated", alu_b, 0);
    @(negedge clk) rst_n = 1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fair%0d_r0_ready", i), r0_ready, i % 2 == 0);
      check($sformatf("fair%0d_r1_ready", i), r1_ready, i % 2 == 1);
      tick();
      check($sformatf("fair%0d_p0_valid", i), p0_valid, i % 2 == 0);
      check($sformatf("fair%0d_p1_valid", i), p1_valid, i % 2 == 1);
      check($sformatf("fair%0d_data", i), i % 2 == 0 ? p0_data : p1_data, i % 2 == 0 ? 101 : 202);
    end
    r0_valid = 0; r1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("idle%0d_alu", i), alu_a | alu_b | {27'd0, alu_sel}, 0);
      check($sformatf("idle%0d_ready", i), r0_ready | r1_ready, 0);
      tick();
      check($sformatf("idle%0d_ptr", i), dut.ptr, 0);
      check($sformatf("idle%0d_pvalid", i), p0_valid | p1_valid, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
